unidad_fetch: RTL and testbench

UNIDAD_FETCH -- requirements
Module: unidad_fetch

---
 rtl/unidad_fetch.sv | 54 +++++
 tb/tb_unidad_fetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_fetch.sv
// unidad_fetch: instruction fetch unit with IDLE/FETCH/HOLD handshake and jump/branch/sequential redirect.
module unidad_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_target,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);
   localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};
   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
   state_t state, state_nx;
   logic [31:0] fetch_pc, next_pc;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state == IDLE ? FETCH :
                 state == FETCH ? (imem_ack ? HOLD : FETCH) :
                 state == HOLD ? (stall ? HOLD : FETCH) : IDLE;
      imem_req = state == FETCH;
   end
   assign imem_addr = {fetch_pc[31:2], 2'b00};
   assign pc_plus4 = pc + 32'd4;
   // Redirect priority: jump beats branch beats fall-through; all sums wrap mod 2^32.
   assign next_pc = jump ? {pc_plus4[31:28], jump_target, 2'b00} :
                    branch_taken ? pc_plus4 + {branch_offset[29:0], 2'b00} : pc_plus4;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= START_PC;
         instr <= '0;
         pc <= '0;
         instr_valid <= 1'b0;
      end else if (state == FETCH && imem_ack) begin
         instr <= imem_data;
         pc <= fetch_pc;
         instr_valid <= 1'b1;
      end else if (state == HOLD && !stall) begin
         fetch_pc <= next_pc;
         instr_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_unidad_fetch.sv
// tb_unidad_fetch: randomized bench for unidad_fetch against an address-arithmetic reference model.
module tb_unidad_fetch;
   logic clk = 0, rst_n = 0, imem_req, imem_ack = 0, stall = 1, branch_taken = 0, jump = 0, instr_valid;
   logic [31:0] imem_addr, imem_data = 0, branch_offset = 0, instr, pc, pc_plus4;
   logic [25:0] jump_target = 0;
   int total = 0, bad = 0;
   logic [31:0] m_pc, m_instr;

   unidad_fetch dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_data(imem_data), .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
      .jump(jump), .jump_target(jump_target), .instr(instr), .instr_valid(instr_valid), .pc(pc),
      .pc_plus4(pc_plus4)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model_next(logic [31:0] p, logic j, logic [25:0] jt, logic b, logic [31:0] off);
      logic [31:0] p4;
      p4 = p + 32'd4;
      if (j) return (p4 & 32'hF000_0000) | ({6'd0, jt} << 2);
      if (b) return p4 + off * 32'd4;
      return p4;
   endfunction

   task automatic wait_req(output logic [31:0] a, output bit ok);
      ok = 0;
      a = 'x;
      for (int i = 0; i < 20; i++) begin
         if (imem_req) begin
            ok = 1;
            a = imem_addr;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic ack_after(input int n, input logic [31:0] d);
      repeat (n) @(negedge clk);
      imem_ack = 1;
      imem_data = d;
      @(negedge clk);
      imem_ack = 0;
   endtask

   // Leaves HOLD with the given redirect, then serves the fetch with data d.
   task automatic step(input logic j, input logic [25:0] jt, input logic b, input logic [31:0] off,
                       input logic [31:0] d, output logic [31:0] got, output bit ok);
      stall = 0; jump = j; jump_target = jt; branch_taken = b; branch_offset = off;
      @(negedge clk);
      stall = 1; jump = 0; branch_taken = 0;
      wait_req(got, ok);
      if (ok) ack_after($urandom_range(0, 3), d);
   endtask

   task automatic goto(input logic [31:0] target, output logic [31:0] got, output bit ok);
      logic [31:0] off;
      off = (target - m_pc - 32'd4) >> 2;
      m_instr = $urandom;
      step(0, 0, 1, off, m_instr, got, ok);
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      total++;
      if ({imem_req, imem_addr, instr, pc, instr_valid} !== 98'd0) begin
         bad++;
         $display("FAIL reset_state req=%b addr=%h instr=%h pc=%h valid=%b want all zero", imem_req, imem_addr, instr, pc, instr_valid);
      end
      rst_n = 1;
      @(negedge clk);
      total++;
      if (imem_req !== 1 || imem_addr !== 32'h0) begin
         bad++;
         $display("FAIL first_req req=%b addr=%h want 1 00000000", imem_req, imem_addr);
      end
      repeat (2) begin
         @(negedge clk);
         total++;
         if (imem_req !== 1 || imem_addr !== 32'h0 || instr_valid !== 0) begin
            bad++;
            $display("FAIL req_stable req=%b addr=%h valid=%b want 1 00000000 0", imem_req, imem_addr, instr_valid);
         end
      end
      ack_after(0, 32'h2008_0005);
      total++;
      if (instr !== 32'h2008_0005 || pc !== 32'h0 || instr_valid !== 1 || imem_req !== 0) begin
         bad++;
         $display("FAIL first_fetch instr=%h pc=%h valid=%b req=%b want 20080005 00000000 1 0", instr, pc, instr_valid, imem_req);
      end
      m_pc = 0;
      m_instr = 32'h2008_0005;
   endtask

   task automatic test_branch_back;
      logic [31:0] got;
      bit ok;
      goto(32'h10, got, ok);
      total++;
      if (!ok || pc !== 32'h10) begin
         bad++;
         $display("FAIL goto_10 ok=%0d pc=%h want 00000010", ok, pc);
      end
      m_pc = 32'h10;
      m_instr = $urandom;
      step(0, 0, 1, 32'hFFFF_FFFE, m_instr, got, ok);
      total++;
      if (!ok || got !== 32'hC || pc !== 32'hC || instr !== m_instr) begin
         bad++;
         $display("FAIL branch_back ok=%0d addr=%h pc=%h instr=%h want 0000000c 0000000c %h", ok, got, pc, instr, m_instr);
      end
      m_pc = 32'hC;
   endtask

   task automatic test_jump_priority;
      logic [31:0] got;
      bit ok;
      goto(32'h4000_0000, got, ok);
      total++;
      if (!ok || got !== 32'h4000_0000 || pc !== 32'h4000_0000) begin
         bad++;
         $display("FAIL goto_40000000 ok=%0d addr=%h pc=%h want 40000000", ok, got, pc);
      end
      m_pc = 32'h4000_0000;
      m_instr = $urandom;
      step(1, 26'h100, 1, $urandom, m_instr, got, ok);
      total++;
      if (!ok || got !== 32'h4000_0400 || pc !== 32'h4000_0400) begin
         bad++;
         $display("FAIL jump_wins ok=%0d addr=%h pc=%h want 40000400", ok, got, pc);
      end
      m_pc = 32'h4000_0400;
   endtask

   task automatic test_stall;
      logic [31:0] got;
      bit ok;
      for (int i = 0; i < 5; i++) begin
         branch_taken = i[0];
         branch_offset = $urandom;
         imem_ack = 1'($urandom);
         imem_data = $urandom;
         @(negedge clk);
         total++;
         if (instr !== m_instr || pc !== m_pc || instr_valid !== 1 || imem_req !== 0) begin
            bad++;
            $display("FAIL stall_hold instr=%h pc=%h valid=%b req=%b want %h %h 1 0", instr, pc, instr_valid, imem_req, m_instr, m_pc);
         end
      end
      branch_taken = 0;
      imem_ack = 0;
      m_instr = $urandom;
      step(0, 0, 0, 0, m_instr, got, ok);
      total++;
      if (!ok || got !== m_pc + 32'd4 || pc !== m_pc + 32'd4) begin
         bad++;
         $display("FAIL after_stall ok=%0d addr=%h pc=%h want %h", ok, got, pc, m_pc + 32'd4);
      end
      m_pc = m_pc + 32'd4;
   endtask

   task automatic test_wrap;
      logic [31:0] got;
      bit ok;
      goto(32'hFFFF_FFFC, got, ok);
      total++;
      if (!ok || pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
         bad++;
         $display("FAIL goto_top ok=%0d pc=%h pc_plus4=%h want fffffffc 00000000", ok, pc, pc_plus4);
      end
      m_pc = 32'hFFFF_FFFC;
      m_instr = $urandom;
      step(0, 0, 0, 0, m_instr, got, ok);
      total++;
      if (!ok || got !== 32'h0 || pc !== 32'h0) begin
         bad++;
         $display("FAIL seq_wrap ok=%0d addr=%h pc=%h want 00000000", ok, got, pc);
      end
      m_pc = 0;
   endtask

   task automatic test_random;
      logic [31:0] got, exp, off;
      logic [25:0] jt;
      logic j, b;
      bit ok;
      for (int i = 0; i < 20; i++) begin
         j = ($urandom_range(0, 3) == 0);
         b = 1'($urandom);
         jt = 26'($urandom);
         off = $urandom_range(0, 1) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
         exp = model_next(m_pc, j, jt, b, off);
         m_instr = $urandom;
         step(j, jt, b, off, m_instr, got, ok);
         total++;
         if (!ok || got !== exp || pc !== exp || instr !== m_instr || instr_valid !== 1 || pc_plus4 !== exp + 32'd4) begin
            bad++;
            $display("FAIL random_%0d ok=%0d addr=%h pc=%h instr=%h valid=%b p4=%h want %h %h 1", i, ok, got, pc, instr, instr_valid, pc_plus4, exp, m_instr);
         end
         m_pc = exp;
      end
   endtask

   task automatic test_reset_mid_fetch;
      logic [31:0] got, d;
      bit ok;
      stall = 0;
      @(negedge clk);
      stall = 1;
      wait_req(got, ok);
      imem_ack = 1;
      imem_data = $urandom;
      rst_n = 0;
      #1;
      total++;
      if (!ok || {imem_req, imem_addr, instr, pc, instr_valid} !== 98'd0) begin
         bad++;
         $display("FAIL async_reset ok=%0d req=%b addr=%h instr=%h pc=%h valid=%b want zeros", ok, imem_req, imem_addr, instr, pc, instr_valid);
      end
      @(negedge clk);
      total++;
      if (instr_valid !== 0 || instr !== 0 || imem_req !== 0) begin
         bad++;
         $display("FAIL ack_dropped valid=%b instr=%h req=%b want 0 0 0", instr_valid, instr, imem_req);
      end
      imem_ack = 0;
      rst_n = 1;
      @(negedge clk);
      total++;
      if (imem_req !== 1 || imem_addr !== 32'h0) begin
         bad++;
         $display("FAIL refetch req=%b addr=%h want 1 00000000", imem_req, imem_addr);
      end
      d = $urandom;
      ack_after(1, d);
      total++;
      if (pc !== 0 || instr !== d || instr_valid !== 1) begin
         bad++;
         $display("FAIL refetch_data pc=%h instr=%h valid=%b want 00000000 %h 1", pc, instr, instr_valid, d);
      end
   endtask

   initial begin
      test_reset;
      test_branch_back;
      test_jump_priority;
      test_stall;
      test_wrap;
      test_random;
      test_reset_mid_fetch;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
